aer_event_encoder: RTL

Downstream of the row/column arbiter top in the event-camera readout path. Consumes the one-hot row grant and column grant vectors. Encodes each granted pixel into a binary address-event word {timestamp, x, y}. Buffers events in a first-word-fall-through FIFO and presents them on a valid/ready stream to the readout interface.

---
 rtl/aer_event_encoder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/aer_event_encoder.sv
// -----------------------------------------------------------------------------
// aer_event_encoder
//
// Purpose:
//   Turns the one-hot row/column grants from the pixel arbiter into binary
//   address-event words {timestamp, x, y}. The words are buffered in a
//   first-word-fall-through FIFO and offered on a valid/ready stream.
//
// Ports:
//   clk_i        rising-edge clock
//   reset_i      asynchronous, active-high reset
//   enable_i     runs the timestamp counter and event capture
//   x_gnt_i      one-hot row grant (ROWS bits)
//   y_gnt_i      one-hot column grant (COLS bits)
//   event_o      FIFO head word {ts, x, y}
//   valid_o      FIFO non-empty
//   ready_i      consumer takes event_o this cycle
//   count_o      FIFO occupancy
//   overflow_o   sticky: an event was dropped because the FIFO was full
//   proto_err_o  sticky: a grant vector was multi-hot
//   clear_i      clears both sticky flags (a same-cycle set wins)
// -----------------------------------------------------------------------------
module aer_event_encoder #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int TS_WIDTH   = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                                   clk_i,
    input  logic                                                   reset_i,
    input  logic                                                   enable_i,
    input  logic [ROWS-1:0]                                        x_gnt_i,
    input  logic [COLS-1:0]                                        y_gnt_i,
    output logic [TS_WIDTH+$clog2(ROWS)+$clog2(COLS)-1:0]          event_o,
    output logic                                                   valid_o,
    input  logic                                                   ready_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]                        count_o,
    output logic                                                   overflow_o,
    output logic                                                   proto_err_o,
    input  logic                                                   clear_i
);

    localparam int XW = $clog2(ROWS);
    localparam int YW = $clog2(COLS);
    localparam int EW = TS_WIDTH + XW + YW;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    // State
    logic [TS_WIDTH-1:0]                ts_q, ts_d;
    logic                               prev_vld_q, prev_vld_d;
    logic [XW-1:0]                      prev_x_q, prev_x_d;
    logic [YW-1:0]                      prev_y_q, prev_y_d;
    logic [FIFO_DEPTH-1:0][EW-1:0]      mem_q, mem_d;
    logic [PW-1:0]                      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                      count_q, count_d;
    logic                               overflow_q, overflow_d;
    logic                               proto_err_q, proto_err_d;

    // Grant decode
    logic          x_any, y_any, x_multi, y_multi, pair_vld;
    logic [XW-1:0] x_idx;
    logic [YW-1:0] y_idx;
    logic          new_pair, capture, full, empty, push, pop, drop;

    assign x_any   = |x_gnt_i;
    assign y_any   = |y_gnt_i;
    // v & (v-1) clears the lowest set bit; anything left means more than one bit.
    assign x_multi = |(x_gnt_i & (x_gnt_i - ROWS'(1)));
    assign y_multi = |(y_gnt_i & (y_gnt_i - COLS'(1)));
    assign pair_vld = x_any & ~x_multi & y_any & ~y_multi;

    // OR of bit positions is the index when the vector is one-hot; the
    // result is ignored whenever the vector is not.
    always_comb begin
        x_idx = '0;
        for (int i = 0; i < ROWS; i++)
            if (x_gnt_i[i]) x_idx = x_idx | XW'(i);
    end

    always_comb begin
        y_idx = '0;
        for (int j = 0; j < COLS; j++)
            if (y_gnt_i[j]) y_idx = y_idx | YW'(j);
    end

    // A held grant produces one event: only a fresh or changed pair captures.
    assign new_pair = ~prev_vld_q | (x_idx != prev_x_q) | (y_idx != prev_y_q);
    assign capture  = enable_i & pair_vld & new_pair;

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign pop   = ~empty & ready_i;
    // A pop frees the slot for a same-cycle push even when full.
    assign push  = capture & (~full | pop);
    assign drop  = capture & full & ~pop;

    always_comb begin
        ts_d        = enable_i ? ts_q + TS_WIDTH'(1) : ts_q;
        prev_vld_d  = pair_vld;
        prev_x_d    = x_idx;
        prev_y_d    = y_idx;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = {ts_q, x_idx, y_idx};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);

        // Clear first so a same-cycle set takes priority.
        overflow_d  = clear_i ? 1'b0 : overflow_q;
        proto_err_d = clear_i ? 1'b0 : proto_err_q;
        if (drop)
            overflow_d = 1'b1;
        if (enable_i && (x_multi || y_multi))
            proto_err_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ts_q        <= '0;
            prev_vld_q  <= 1'b0;
            prev_x_q    <= '0;
            prev_y_q    <= '0;
            mem_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            ts_q        <= ts_d;
            prev_vld_q  <= prev_vld_d;
            prev_x_q    <= prev_x_d;
            prev_y_q    <= prev_y_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Outputs come straight from state; the head word is a read of the
    // storage registers so it stays put until the head pointer moves.
    assign event_o     = mem_q[rd_ptr_q];
    assign valid_o     = ~empty;
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign proto_err_o = proto_err_q;

endmodule
